// File: rtl/cmd_dispatch_if.sv
// rtl/cmd_dispatch_if.sv - USB command/completion handshake bundle for cmd_dispatch
interface cmd_dispatch_if;
    logic        i_cmd_come;
    logic [15:0] i_cmd;
    logic [31:0] i_cmd_param;
    logic        o_cmd_finish;
    logic [15:0] o_cmd_finish_code;

    modport master (
        output i_cmd_come,
        output i_cmd,
        output i_cmd_param,
        input  o_cmd_finish,
        input  o_cmd_finish_code
    );

    modport slave (
        input  i_cmd_come,
        input  i_cmd,
        input  i_cmd_param,
        output o_cmd_finish,
        output o_cmd_finish_code
    );
endinterface

// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - USB command decoder driving acquisition configuration and handshakes
module cmd_dispatch #(
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter logic [31:0] PRF_MIN = 32'd100,
    parameter logic [13:0] SMP_MAX = 14'd8192
) (
    input  logic                i_clk_usb,
    input  logic                i_rst_n,
    cmd_dispatch_if.slave       cmd_bus,
    input  logic                i_gain_ack,
    input  logic                i_acq_idle,
    output logic [31:0]         o_prf_period,
    output logic [7:0]          o_gain,
    output logic [13:0]         o_samples,
    output logic                o_gain_req,
    output logic                o_run,
    output logic                o_busy
);

    localparam logic [15:0] OP_SET_PRF  = 16'h0001;
    localparam logic [15:0] OP_SET_GAIN = 16'h0002;
    localparam logic [15:0] OP_SET_SMP  = 16'h0003;
    localparam logic [15:0] OP_START    = 16'h0004;
    localparam logic [15:0] OP_STOP     = 16'h0005;

    localparam logic [15:0] RC_OK      = 16'h0000;
    localparam logic [15:0] RC_UNKNOWN = 16'h0001;
    localparam logic [15:0] RC_ILLEGAL = 16'h0002;
    localparam logic [15:0] RC_BUSY    = 16'h0003;
    localparam logic [15:0] RC_TIMEOUT = 16'h0004;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT_ACK,
        WAIT_IDLE,
        FIN_LO,
        FIN_HI
    } state_t;

    state_t      state_q;
    logic        come_q;
    logic [15:0] cmd_q;
    logic [31:0] param_q;
    logic [15:0] cnt_q;
    logic        finish_q;
    logic [15:0] code_q;
    logic [31:0] prf_q;
    logic [7:0]  gain_q;
    logic [13:0] smp_q;
    logic        gain_req_q;
    logic        run_q;
    logic        busy_q;

    logic        come_edge;
    logic        cnt_expired;
    logic [15:0] dec_code;
    logic        dec_wait_ack;
    logic        dec_wait_idle;

    // Edge register resets high so a level already present at reset release is not a command
    always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
        if (!i_rst_n) begin
            come_q <= 1'b1;
        end else begin
            come_q <= cmd_bus.i_cmd_come;
        end
    end

    // Decode the latched command into a result code and whether it must wait for a handshake
    always_comb begin
        come_edge     = cmd_bus.i_cmd_come & ~come_q;
        cnt_expired   = (cnt_q == (TIMEOUT - 16'd1));
        dec_code      = RC_OK;
        dec_wait_ack  = 1'b0;
        dec_wait_idle = 1'b0;
        case (cmd_q)
            OP_SET_PRF: begin
                if (run_q)                    dec_code = RC_BUSY;
                else if (param_q < PRF_MIN)   dec_code = RC_ILLEGAL;
            end
            OP_SET_GAIN: begin
                if (run_q)                           dec_code = RC_BUSY;
                else if (param_q[31:8] != 24'd0)     dec_code = RC_ILLEGAL;
                else                                 dec_wait_ack = 1'b1;
            end
            OP_SET_SMP: begin
                if (run_q)                                              dec_code = RC_BUSY;
                else if ((param_q == 32'd0) || (param_q > {18'd0, SMP_MAX})) dec_code = RC_ILLEGAL;
            end
            OP_START: begin
                if (run_q) dec_code = RC_BUSY;
            end
            OP_STOP: begin
                // Stopping an already stopped engine completes at once
                dec_wait_idle = run_q;
            end
            default: dec_code = RC_UNKNOWN;
        endcase
    end

    // Command sequencer: decode, optional handshake wait, then a 3-low/1-high finish pulse
    always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= 16'd0;
            param_q    <= 32'd0;
            cnt_q      <= 16'd0;
            finish_q   <= 1'b1;
            code_q     <= RC_OK;
            prf_q      <= 32'd100000;
            gain_q     <= 8'd0;
            smp_q      <= 14'd1024;
            gain_req_q <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (come_edge) begin
                        cmd_q   <= cmd_bus.i_cmd;
                        param_q <= cmd_bus.i_cmd_param;
                        state_q <= DECODE;
                        busy_q  <= 1'b1;
                    end
                end
                DECODE: begin
                    cnt_q <= 16'd0;
                    if (dec_wait_ack) begin
                        // Gain is applied now; a later timeout only changes the reported code
                        gain_q     <= param_q[7:0];
                        gain_req_q <= 1'b1;
                        state_q    <= WAIT_ACK;
                    end else if (dec_wait_idle) begin
                        run_q   <= 1'b0;
                        state_q <= WAIT_IDLE;
                    end else begin
                        code_q   <= dec_code;
                        finish_q <= 1'b0;
                        state_q  <= FIN_LO;
                        if (dec_code == RC_OK) begin
                            case (cmd_q)
                                OP_SET_PRF: prf_q <= param_q;
                                OP_SET_SMP: smp_q <= param_q[13:0];
                                OP_START:   run_q <= 1'b1;
                                default:    ;
                            endcase
                        end
                    end
                end
                WAIT_ACK: begin
                    if (i_gain_ack || cnt_expired) begin
                        gain_req_q <= 1'b0;
                        code_q     <= i_gain_ack ? RC_OK : RC_TIMEOUT;
                        finish_q   <= 1'b0;
                        cnt_q      <= 16'd0;
                        state_q    <= FIN_LO;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    // o_run was already cleared in DECODE and stays low on timeout
                    if (i_acq_idle || cnt_expired) begin
                        code_q   <= i_acq_idle ? RC_OK : RC_TIMEOUT;
                        finish_q <= 1'b0;
                        cnt_q    <= 16'd0;
                        state_q  <= FIN_LO;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                FIN_LO: begin
                    if (cnt_q == 16'd2) begin
                        finish_q <= 1'b1;
                        cnt_q    <= 16'd0;
                        state_q  <= FIN_HI;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                FIN_HI: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    finish_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_bus.o_cmd_finish      = finish_q;
    assign cmd_bus.o_cmd_finish_code = code_q;
    assign o_prf_period              = prf_q;
    assign o_gain                    = gain_q;
    assign o_samples                 = smp_q;
    assign o_gain_req                = gain_req_q;
    assign o_run                     = run_q;
    assign o_busy                    = busy_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb/tb_cmd_dispatch.sv - scoreboard bench for cmd_dispatch
module tb_cmd_dispatch;

    localparam logic [15:0] TB_TIMEOUT = 16'd200;

    typedef struct {
        logic [15:0] code;
        logic [31:0] prf;
        logic [7:0]  gain;
        logic [13:0] smp;
        logic        run;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        gain_ack;
    logic        acq_idle;
    logic [31:0] prf_period;
    logic [7:0]  gain;
    logic [13:0] samples;
    logic        gain_req;
    logic        run;
    logic        busy;

    int   n_total;
    int   n_pass;
    int   n_pulses;
    int   n_pushed;
    exp_t sb[$];

    cmd_dispatch_if bus ();

    cmd_dispatch #(.TIMEOUT(TB_TIMEOUT)) dut (
        .i_clk_usb    (clk),
        .i_rst_n      (rst_n),
        .cmd_bus      (bus.slave),
        .i_gain_ack   (gain_ack),
        .i_acq_idle   (acq_idle),
        .o_prf_period (prf_period),
        .o_gain       (gain),
        .o_samples    (samples),
        .o_gain_req   (gain_req),
        .o_run        (run),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [15:0] c, input logic [31:0] p, input logic [7:0] g,
                        input logic [13:0] s, input logic r);
        exp_t e;
        e.code = c; e.prf = p; e.gain = g; e.smp = s; e.run = r;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic issue(input logic [15:0] op, input logic [31:0] p);
        @(negedge clk);
        bus.i_cmd_come = 1'b0;
        @(negedge clk);
        bus.i_cmd       = op;
        bus.i_cmd_param = p;
        bus.i_cmd_come  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.i_cmd_come  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 1000), 32'd1);
    endtask

    task automatic gain_cmd(input logic [31:0] p, input int ack_after, input int exp_hi);
        int hi;
        hi = 0;
        issue(16'h0002, p);
        for (int i = 0; i < 400; i++) begin
            if (gain_req === 1'b1) hi++;
            else if (hi > 0) break;
            if (ack_after > 0 && hi == ack_after) gain_ack = 1'b1;
            @(negedge clk);
        end
        gain_ack = 1'b0;
        check("gain_req_cycles", 32'(hi), 32'(exp_hi));
        wait_idle("gain_done");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_finish"},   32'(bus.o_cmd_finish), 32'd1);
        check({tag, "_code"},     32'(bus.o_cmd_finish_code), 32'd0);
        check({tag, "_prf"},      prf_period, 32'd100000);
        check({tag, "_gain"},     32'(gain), 32'd0);
        check({tag, "_samples"},  32'(samples), 32'd1024);
        check({tag, "_gain_req"}, 32'(gain_req), 32'd0);
        check({tag, "_run"},      32'(run), 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
    endtask

    // Monitor: on each finish rising edge, pop the expected response and compare
    initial begin
        logic prev;
        int   lo;
        exp_t e;
        prev = 1'b1;
        lo   = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev = 1'b1;
                lo   = 0;
            end else begin
                if (bus.o_cmd_finish === 1'b0) lo++;
                if (prev === 1'b0 && bus.o_cmd_finish === 1'b1) begin
                    n_pulses++;
                    check("finish_low_len", 32'(lo), 32'd3);
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_finish: got code 0x%0h expected no pulse",
                                 bus.o_cmd_finish_code);
                    end else begin
                        e = sb.pop_front();
                        check("sb_code",    32'(bus.o_cmd_finish_code), 32'(e.code));
                        check("sb_prf",     prf_period, e.prf);
                        check("sb_gain",    32'(gain), 32'(e.gain));
                        check("sb_samples", 32'(samples), 32'(e.smp));
                        check("sb_run",     32'(run), 32'(e.run));
                    end
                    lo = 0;
                end
                prev = bus.o_cmd_finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int saw_busy;
        int pulses_before;
        n_total = 0; n_pass = 0; n_pulses = 0; n_pushed = 0;
        rst_n = 1'b0;
        gain_ack = 1'b0;
        acq_idle = 1'b0;
        bus.i_cmd_come  = 1'b0;
        bus.i_cmd       = 16'd0;
        bus.i_cmd_param = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // SET_PRF 1000 with cycle-exact finish timing
        push(16'h0000, 32'd1000, 8'h00, 14'd1024, 1'b0);
        bus.i_cmd = 16'h0001; bus.i_cmd_param = 32'd1000; bus.i_cmd_come = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus.i_cmd_come = 1'b0;
            check($sformatf("lat_finish_c%0d", k), 32'(bus.o_cmd_finish), 32'((k >= 2 && k <= 4) ? 0 : 1));
            check($sformatf("lat_busy_c%0d", k), 32'(busy), 32'((k <= 5) ? 1 : 0));
        end

        // Parameter range boundaries
        push(16'h0002, 32'd1000, 8'h00, 14'd1024, 1'b0); issue(16'h0003, 32'd0);    wait_idle("smp0");
        push(16'h0002, 32'd1000, 8'h00, 14'd1024, 1'b0); issue(16'h0003, 32'd8193); wait_idle("smp8193");
        push(16'h0000, 32'd1000, 8'h00, 14'd8192, 1'b0); issue(16'h0003, 32'd8192); wait_idle("smp8192");
        push(16'h0002, 32'd1000, 8'h00, 14'd8192, 1'b0); issue(16'h0001, 32'd99);   wait_idle("prf99");
        push(16'h0000, 32'd100,  8'h00, 14'd8192, 1'b0); issue(16'h0001, 32'd100);  wait_idle("prf100");
        push(16'h0002, 32'd100,  8'h00, 14'd8192, 1'b0); issue(16'h0002, 32'h100);  wait_idle("gain_ill");

        // Gain write: acknowledged after 10 cycles, then never acknowledged
        push(16'h0000, 32'd100, 8'h5A, 14'd8192, 1'b0); gain_cmd(32'h5A, 10, 10);
        push(16'h0004, 32'd100, 8'h33, 14'd8192, 1'b0); gain_cmd(32'h33, 0, int'(TB_TIMEOUT));

        // Run control and busy rejection
        push(16'h0000, 32'd100, 8'h33, 14'd8192, 1'b1); issue(16'h0004, 32'd0);    wait_idle("start");
        push(16'h0003, 32'd100, 8'h33, 14'd8192, 1'b1); issue(16'h0001, 32'd5000); wait_idle("prf_busy");
        push(16'h0003, 32'd100, 8'h33, 14'd8192, 1'b1); issue(16'h0004, 32'd0);    wait_idle("start_busy");
        push(16'h0000, 32'd100, 8'h33, 14'd8192, 1'b0); issue(16'h0005, 32'd0);
        repeat (20) @(negedge clk);
        check("stop_waiting", 32'(busy), 32'd1);
        acq_idle = 1'b1;
        wait_idle("stop");
        acq_idle = 1'b0;
        push(16'h0000, 32'd100, 8'h33, 14'd8192, 1'b0); issue(16'h0005, 32'd0);    wait_idle("stop_idle");
        push(16'h0000, 32'd100, 8'h33, 14'd8192, 1'b1); issue(16'h0004, 32'd0);    wait_idle("start2");
        push(16'h0004, 32'd100, 8'h33, 14'd8192, 1'b0); issue(16'h0005, 32'd0);    wait_idle("stop_to");

        // Unknown opcode with a stray edge during FIN_LO
        push(16'h0001, 32'd100, 8'h33, 14'd8192, 1'b0);
        issue(16'h00FF, 32'd0);
        @(negedge clk);
        bus.i_cmd_come = 1'b1;
        wait_idle("unknown");
        repeat (4) @(negedge clk);
        bus.i_cmd_come = 1'b0;
        repeat (10) @(negedge clk);
        check("stray_edge_pulses", 32'(n_pulses), 32'(n_pushed));

        // Reset mid-command in WAIT_ACK, with i_cmd_come held high across release
        issue(16'h0002, 32'h77);
        repeat (5) @(negedge clk);
        check("in_wait_ack", 32'(gain_req), 32'd1);
        #2;
        rst_n = 1'b0;
        bus.i_cmd_come = 1'b1;
        #1;
        check_reset_values("midrst");
        pulses_before = n_pulses;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        saw_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1;
        end
        check("held_come_ignored", 32'(saw_busy), 32'd0);
        check("held_come_no_pulse", 32'(n_pulses), 32'(pulses_before));
        push(16'h0000, 32'd777, 8'h00, 14'd1024, 1'b0); issue(16'h0001, 32'd777); wait_idle("post_rst");

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("pulse_total", 32'(n_pulses), 32'(n_pushed));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
